health_manager_gen: RTL and testbench
=====================================

# health_manager_gen

Parametrised two-fighter health and match controller. Sits between the hit-detection logic (melee range, projectile collision) and the HUD/renderer. It applies typed, blockable damage with per-fighter invincibility frames, detects KOs, and runs a best-of-N round/match state machine. Health, round counts and state drive the health bars, hit-flash effects and win screens.

## Interface
Parameters:
- HEALTH_W, 9: width of each health value
- MAX_HEALTH, 400: health loaded at round start; must be < 2**HEALTH_W
- DMG_LIGHT, 5: damage for a light hit
- DMG_HEAVY, 10: damage for a heavy hit
- DMG_PROJ, 15: damage for a projectile hit
- IFRAME_CYCLES, 8: invincibility length after an applied hit; 0 disables i-frames
- KO_HOLD_CYCLES, 16: cycles spent in KO before the next round or match end
- ROUNDS_TO_WIN, 2: round wins needed to take the match

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin match; honoured only in IDLE or MATCH_OVER
- hit_p1 / hit_p2  in  2  hit type against that fighter: 00 none, 01 light, 10 heavy, 11 projectile
- block_p1 / block_p2  in  1  defender is blocking
- health_p1 / health_p2  out  HEALTH_W  current health
- rounds_p1 / rounds_p2  out  $clog2(ROUNDS_TO_WIN+1)  rounds won
- hit_pulse_p1 / hit_pulse_p2  out  1  one-cycle pulse when damage is applied
- iframe_p1 / iframe_p2  out  1  fighter is currently invulnerable
- state  out  2  00 IDLE, 01 FIGHT, 10 KO, 11 MATCH_OVER
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw (last resolved round, or the match in MATCH_OVER)

## Operation
- Reset: health = MAX_HEALTH for both fighters. Rounds, pulses, iframes, i-frame counters and KO counter = 0. state = IDLE. winner = 00.
- IDLE or MATCH_OVER with start=1:
  - Go to FIGHT.
  - Reload both health values, clear rounds, i-frames and winner.
- FIGHT, per fighter, each cycle:
  - A hit is applied when hit_px != 00 and the i-frame counter is 0.
  - dmg = table value. If block_px=1, dmg = dmg >> 1 (chip damage).
  - health <= (health > dmg) ? health - dmg : 0.
  - On an applied hit: hit_pulse = 1, i-frame counter loads IFRAME_CYCLES.
  - Hits during i-frames are dropped, with no pulse.
  - Hits to both fighters in the same cycle are both applied.
- KO detection uses the next-health values in the same cycle:
  - If either next health is 0: go to KO and load the KO counter with KO_HOLD_CYCLES.
  - Exactly one fighter at 0: the opponent's rounds increments; winner = that opponent.
  - Both at 0 (double KO): winner = 11, no round awarded.
- KO:
  - Hits ignored; the KO counter decrements.
  - When the counter reaches 0: if a rounds value equals ROUNDS_TO_WIN, go to MATCH_OVER. Otherwise go to FIGHT, reload health and clear i-frames.
- MATCH_OVER: holds all values until start.
- Outside FIGHT: hit inputs ignored, hit pulses 0, i-frame counters frozen at 0.

## Timing
- Hit sampled at edge N: health, hit_pulse and iframe update visibly at N+1. hit_pulse drops at N+2 unless a new hit is applied.
- iframe stays high for exactly IFRAME_CYCLES cycles after the pulse cycle. The next hit is accepted on the first cycle iframe reads 0.
- The KO transition is visible in the same cycle as health = 0. The next round starts KO_HOLD_CYCLES+1 cycles after entering KO.
- reset has priority over start and all hits. Reset mid-round or mid-KO returns to the reset values on the next cycle.
- All counters saturate; no wrap-around.

## Structure
- Package health_pkg holds:
  - state encodings IDLE, FIGHT, KO, MATCH_OVER
  - hit type encodings HIT_NONE, HIT_LIGHT, HIT_HEAVY, HIT_PROJ
  - winner encodings
- Sub-module fighter_health_channel, instantiated twice. It contains the health register, damage table, block halving, i-frame counter and hit pulse. Outputs: next_health_zero and health.
- Top level contains the match FSM, KO counter and round counters.

## Test plan
- Defaults, start, light hit to P2 with no block -> health_p2 = 395 at N+1, hit_pulse_p2 high one cycle, iframe_p2 high 8 cycles.
- Heavy hit to P1 with block_p1=1, followed by a projectile 3 cycles later -> health_p1 = 395; the projectile is dropped with no pulse. A projectile 9 cycles after the heavy hit -> health_p1 = 380.
- P2 at health 4, light hit -> health_p2 = 0, state = KO the same cycle, rounds_p1 = 1, winner = 01. After 17 cycles state = FIGHT and both health = 400.
- Both fighters at health 10, heavy hits to both in the same cycle -> both 0, winner = 11, rounds unchanged, round replayed.
- P1 wins a second round -> state = MATCH_OVER after the KO hold; hits ignored; start -> FIGHT with rounds cleared.
- Reset asserted mid-KO -> next cycle: state = IDLE, health = 400/400, rounds 0, all pulses and iframes 0.

Source files
------------

// File: rtl/health_manager_gen_pkg.sv
// health_pkg: shared encodings for the two-fighter health and match controller.
package health_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, FIGHT = 2'b01, KO = 2'b10, MATCH_OVER = 2'b11} state_e;
    typedef enum logic [1:0] {HIT_NONE = 2'b00, HIT_LIGHT = 2'b01, HIT_HEAVY = 2'b10, HIT_PROJ = 2'b11} hit_e;
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;
endpackage

// File: rtl/health_manager_gen_if.sv
// health_manager_gen_if: hit-detection inputs and HUD-facing outputs of the health manager.
interface health_manager_gen_if #(
    parameter int HEALTH_W = 9,
    parameter int RW       = 2
);
    logic                start;
    logic [1:0]          hit_p1, hit_p2;
    logic                block_p1, block_p2;
    logic [HEALTH_W-1:0] health_p1, health_p2;
    logic [RW-1:0]       rounds_p1, rounds_p2;
    logic                hit_pulse_p1, hit_pulse_p2;
    logic                iframe_p1, iframe_p2;
    logic [1:0]          state;
    logic [1:0]          winner;
    modport master (
        output start, hit_p1, hit_p2, block_p1, block_p2,
        input  health_p1, health_p2, rounds_p1, rounds_p2, hit_pulse_p1, hit_pulse_p2,
               iframe_p1, iframe_p2, state, winner
    );
    modport slave (
        input  start, hit_p1, hit_p2, block_p1, block_p2,
        output health_p1, health_p2, rounds_p1, rounds_p2, hit_pulse_p1, hit_pulse_p2,
               iframe_p1, iframe_p2, state, winner
    );
endinterface

// File: rtl/health_manager_gen_channel.sv
// fighter_health_channel: one fighter's health register, damage table, block halving,
// i-frame counter and hit pulse.
module fighter_health_channel
    import health_pkg::*;
#(
    parameter int HEALTH_W      = 9,
    parameter int MAX_HEALTH    = 400,
    parameter int DMG_LIGHT     = 5,
    parameter int DMG_HEAVY     = 10,
    parameter int DMG_PROJ      = 15,
    parameter int IFRAME_CYCLES = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fight_i,
    input  logic                reload_i,
    input  logic                kill_i,
    input  logic [1:0]          hit_i,
    input  logic                block_i,
    output logic [HEALTH_W-1:0] health_o,
    output logic                next_health_zero_o,
    output logic                hit_pulse_o,
    output logic                iframe_o
);
    localparam int IW = $clog2(IFRAME_CYCLES + 2);
    localparam logic [HEALTH_W-1:0] FULL = HEALTH_W'(MAX_HEALTH);
    localparam logic [HEALTH_W-1:0] D_L  = HEALTH_W'(DMG_LIGHT);
    localparam logic [HEALTH_W-1:0] D_H  = HEALTH_W'(DMG_HEAVY);
    localparam logic [HEALTH_W-1:0] D_P  = HEALTH_W'(DMG_PROJ);
    localparam logic [IW-1:0]       IFR  = IW'(IFRAME_CYCLES);

    logic [HEALTH_W-1:0] health_q, health_d, base, dmg;
    logic [IW-1:0]       ifr_q, ifr_d;
    logic                pulse_q, apply;

    always_comb begin
        base     = (hit_i == HIT_LIGHT) ? D_L : (hit_i == HIT_HEAVY) ? D_H : (hit_i == HIT_PROJ) ? D_P : '0;
        dmg      = block_i ? base >> 1 : base;
        apply    = fight_i && hit_i != HIT_NONE && ifr_q == '0;
        health_d = reload_i ? FULL : !apply ? health_q : (health_q > dmg) ? health_q - dmg : '0;
        // A KO this cycle ends the fight, so no i-frames are carried into KO.
        ifr_d    = (reload_i || !fight_i || kill_i) ? '0 : apply ? IFR : (ifr_q != '0) ? ifr_q - IW'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            health_q <= FULL;
            ifr_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            health_q <= health_d;
            ifr_q    <= ifr_d;
            pulse_q  <= apply;
        end
    end

    assign health_o           = health_q;
    assign next_health_zero_o = fight_i && health_d == '0;
    assign hit_pulse_o        = pulse_q;
    assign iframe_o           = ifr_q != '0;
endmodule

// File: rtl/health_manager_gen.sv
// health_manager_gen: two-fighter damage channels plus the best-of-N round/match FSM,
// KO hold counter and saturating round counters.
module health_manager_gen
    import health_pkg::*;
#(
    parameter int HEALTH_W       = 9,
    parameter int MAX_HEALTH     = 400,
    parameter int DMG_LIGHT      = 5,
    parameter int DMG_HEAVY      = 10,
    parameter int DMG_PROJ       = 15,
    parameter int IFRAME_CYCLES  = 8,
    parameter int KO_HOLD_CYCLES = 16,
    parameter int ROUNDS_TO_WIN  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    health_manager_gen_if.slave  bus
);
    localparam int RW = $clog2(ROUNDS_TO_WIN + 1);
    localparam int KW = $clog2(KO_HOLD_CYCLES + 2);
    localparam logic [RW-1:0] R_WIN   = RW'(ROUNDS_TO_WIN);
    localparam logic [KW-1:0] KO_LOAD = KW'(KO_HOLD_CYCLES);

    state_e        state_q;
    logic [1:0]    winner_q;
    logic [KW-1:0] ko_q;
    logic [RW-1:0] r1_q, r2_q;
    logic          z1, z2, fight, ko_now, ko_done, match_won, reload;

    assign fight     = state_q == FIGHT;
    assign ko_now    = fight && (z1 || z2);
    assign match_won = r1_q == R_WIN || r2_q == R_WIN;
    assign ko_done   = state_q == KO && ko_q == '0;
    assign reload    = ((state_q == IDLE || state_q == MATCH_OVER) && bus.start) || (ko_done && !match_won);

    fighter_health_channel #(
        .HEALTH_W(HEALTH_W), .MAX_HEALTH(MAX_HEALTH), .DMG_LIGHT(DMG_LIGHT),
        .DMG_HEAVY(DMG_HEAVY), .DMG_PROJ(DMG_PROJ), .IFRAME_CYCLES(IFRAME_CYCLES)
    ) u_p1 (
        .clk(clk), .reset(reset), .fight_i(fight), .reload_i(reload), .kill_i(ko_now),
        .hit_i(bus.hit_p1), .block_i(bus.block_p1), .health_o(bus.health_p1),
        .next_health_zero_o(z1), .hit_pulse_o(bus.hit_pulse_p1), .iframe_o(bus.iframe_p1)
    );

    fighter_health_channel #(
        .HEALTH_W(HEALTH_W), .MAX_HEALTH(MAX_HEALTH), .DMG_LIGHT(DMG_LIGHT),
        .DMG_HEAVY(DMG_HEAVY), .DMG_PROJ(DMG_PROJ), .IFRAME_CYCLES(IFRAME_CYCLES)
    ) u_p2 (
        .clk(clk), .reset(reset), .fight_i(fight), .reload_i(reload), .kill_i(ko_now),
        .hit_i(bus.hit_p2), .block_i(bus.block_p2), .health_o(bus.health_p2),
        .next_health_zero_o(z2), .hit_pulse_o(bus.hit_pulse_p2), .iframe_o(bus.iframe_p2)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            winner_q <= WIN_NONE;
            ko_q     <= '0;
            r1_q     <= '0;
            r2_q     <= '0;
        end else begin
            case (state_q)
                IDLE, MATCH_OVER: if (bus.start) begin
                    state_q  <= FIGHT;
                    winner_q <= WIN_NONE;
                    r1_q     <= '0;
                    r2_q     <= '0;
                end
                FIGHT: if (ko_now) begin
                    state_q  <= KO;
                    ko_q     <= KO_LOAD;
                    winner_q <= (z1 && z2) ? WIN_DRAW : z2 ? WIN_P1 : WIN_P2;
                    // A double KO awards nothing and the round is replayed.
                    if (z2 && !z1 && r1_q != R_WIN) r1_q <= r1_q + RW'(1);
                    if (z1 && !z2 && r2_q != R_WIN) r2_q <= r2_q + RW'(1);
                end
                KO: if (ko_done) begin
                    if (match_won) state_q <= MATCH_OVER;
                    else state_q <= FIGHT;
                end else ko_q <= ko_q - KW'(1);
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.state     = state_q;
    assign bus.winner    = winner_q;
    assign bus.rounds_p1 = r1_q;
    assign bus.rounds_p2 = r2_q;
endmodule

// File: tb/tb_health_manager_gen.sv
// tb_health_manager_gen: directed checks of damage, blocking, i-frames, KO, draw,
// match end and mid-KO reset for health_manager_gen.
module tb_health_manager_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    health_manager_gen_if #(.HEALTH_W(9), .RW(2)) bus ();

    health_manager_gen dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One hit cycle, then wait out the i-frames so the next call lands cleanly.
    task automatic hits(input logic [1:0] h1, input logic b1, input logic [1:0] h2, input logic b2);
        bus.hit_p1 = h1; bus.block_p1 = b1; bus.hit_p2 = h2; bus.block_p2 = b2;
        step(1);
        bus.hit_p1 = 2'b00; bus.block_p1 = 1'b0; bus.hit_p2 = 2'b00; bus.block_p2 = 1'b0;
        step(8);
    endtask

    initial begin
        int ic;
        bus.start = 1'b0;
        bus.hit_p1 = 2'b00; bus.hit_p2 = 2'b00;
        bus.block_p1 = 1'b0; bus.block_p2 = 1'b0;
        step(2);
        check("rst_h1", bus.health_p1, 400);
        check("rst_h2", bus.health_p2, 400);
        check("rst_state", bus.state, 0);
        check("rst_winner", bus.winner, 0);
        check("rst_rounds", {bus.rounds_p1, bus.rounds_p2}, 0);
        check("rst_flags", {bus.hit_pulse_p1, bus.hit_pulse_p2, bus.iframe_p1, bus.iframe_p2}, 0);
        reset = 1'b0;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        check("start_state", bus.state, 1);

        // Light hit to P2: 395, one-cycle pulse, 8 i-frame cycles.
        bus.hit_p2 = 2'b01;
        step(1);
        bus.hit_p2 = 2'b00;
        check("light_h2", bus.health_p2, 395);
        check("light_pulse", bus.hit_pulse_p2, 1);
        check("light_iframe", bus.iframe_p2, 1);
        ic = 1;
        step(1);
        check("light_pulse_drop", bus.hit_pulse_p2, 0);
        repeat (11) begin
            ic += int'(bus.iframe_p2);
            step(1);
        end
        check("iframe_len", ic, 8);

        // Blocked heavy, dropped projectile at +3, accepted projectile at +9.
        bus.hit_p1 = 2'b10; bus.block_p1 = 1'b1;
        step(1);
        bus.hit_p1 = 2'b00; bus.block_p1 = 1'b0;
        check("block_h1", bus.health_p1, 395);
        check("block_pulse", bus.hit_pulse_p1, 1);
        step(2);
        bus.hit_p1 = 2'b11;
        step(1);
        bus.hit_p1 = 2'b00;
        check("drop_h1", bus.health_p1, 395);
        check("drop_pulse", bus.hit_pulse_p1, 0);
        step(5);
        bus.hit_p1 = 2'b11;
        step(1);
        bus.hit_p1 = 2'b00;
        check("proj_h1", bus.health_p1, 380);
        check("proj_pulse", bus.hit_pulse_p1, 1);
        step(8);

        // P2 395 -> 4: 25 projectiles (375) + blocked proj 7 + 7 + blocked light 2.
        repeat (25) hits(2'b00, 1'b0, 2'b11, 1'b0);
        hits(2'b00, 1'b0, 2'b11, 1'b1);
        hits(2'b00, 1'b0, 2'b11, 1'b1);
        hits(2'b00, 1'b0, 2'b01, 1'b1);
        check("pre_ko_h2", bus.health_p2, 4);
        bus.hit_p2 = 2'b01;
        step(1);
        bus.hit_p2 = 2'b00;
        check("ko_h2", bus.health_p2, 0);
        check("ko_state", bus.state, 2);
        check("ko_rounds_p1", bus.rounds_p1, 1);
        check("ko_rounds_p2", bus.rounds_p2, 0);
        check("ko_winner", bus.winner, 1);
        check("ko_iframe", bus.iframe_p2, 0);
        step(1);
        bus.hit_p1 = 2'b11;
        step(4);
        check("ko_hit_ignored", bus.hit_pulse_p1, 0);
        check("ko_h1_hold", bus.health_p1, 380);
        bus.hit_p1 = 2'b00;
        step(11);
        check("ko_hold_state", bus.state, 2);
        step(1);
        check("round2_state", bus.state, 1);
        check("round2_h", {23'd0, bus.health_p1 == 9'd400 && bus.health_p2 == 9'd400}, 1);

        // Simultaneous projectiles to 10/10, then a double heavy for a draw.
        repeat (26) hits(2'b11, 1'b0, 2'b11, 1'b0);
        check("both_h1", bus.health_p1, 10);
        check("both_h2", bus.health_p2, 10);
        bus.hit_p1 = 2'b10; bus.hit_p2 = 2'b10;
        step(1);
        bus.hit_p1 = 2'b00; bus.hit_p2 = 2'b00;
        check("draw_h", {bus.health_p1, bus.health_p2}, 0);
        check("draw_winner", bus.winner, 3);
        check("draw_state", bus.state, 2);
        check("draw_rounds", {bus.rounds_p1, bus.rounds_p2}, 4'b0100);
        step(17);
        check("replay_state", bus.state, 1);
        check("replay_h2", bus.health_p2, 400);

        // P1 takes the second round and the match.
        repeat (26) hits(2'b00, 1'b0, 2'b11, 1'b0);
        bus.hit_p2 = 2'b10;
        step(1);
        bus.hit_p2 = 2'b00;
        check("win2_rounds", bus.rounds_p1, 2);
        check("win2_winner", bus.winner, 1);
        step(17);
        check("match_state", bus.state, 3);
        bus.hit_p1 = 2'b11;
        step(2);
        bus.hit_p1 = 2'b00;
        check("match_h1", bus.health_p1, 400);
        check("match_pulse", bus.hit_pulse_p1, 0);
        check("match_winner", bus.winner, 1);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        check("restart_state", bus.state, 1);
        check("restart_rounds", {bus.rounds_p1, bus.rounds_p2}, 0);
        check("restart_winner", bus.winner, 0);
        check("restart_h2", bus.health_p2, 400);

        // Reset in the middle of a KO hold, with a hit pending.
        repeat (26) hits(2'b00, 1'b0, 2'b11, 1'b0);
        bus.hit_p2 = 2'b10;
        step(1);
        bus.hit_p2 = 2'b00;
        check("rko_state", bus.state, 2);
        step(3);
        reset = 1'b1; bus.hit_p1 = 2'b11; bus.start = 1'b1;
        step(1);
        reset = 1'b0; bus.hit_p1 = 2'b00; bus.start = 1'b0;
        check("rko_idle", bus.state, 0);
        check("rko_h", {bus.health_p1, bus.health_p2}, {9'd400, 9'd400});
        check("rko_rounds", {bus.rounds_p1, bus.rounds_p2}, 0);
        check("rko_flags", {bus.hit_pulse_p1, bus.hit_pulse_p2, bus.iframe_p1, bus.iframe_p2}, 0);
        check("rko_winner", bus.winner, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
